// File: rtl/stream_fifo.sv
// First-word-fall-through stream FIFO with level, almost-full/empty flags and flush.
// Define STREAM_FIFO_HWM_EN to enable high-water-mark tracking on hwm_o.
module stream_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int LW      = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             s_valid_i,
    input  logic [WIDTH-1:0] s_data_i,
    output logic             s_ready_o,
    output logic             m_valid_o,
    output logic [WIDTH-1:0] m_data_o,
    input  logic             m_ready_i,
    output logic [LW-1:0]    level_o,
    output logic             almost_full_o,
    output logic             almost_empty_o,
    output logic [LW-1:0]    hwm_o,
    input  logic             hwm_clr_i
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] AF_LVL   = LW'(AF_LEVEL);
    localparam logic [LW-1:0] AE_LVL   = LW'(AE_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push, pop;

    // Handshake status comes from the level register only, never from the inputs.
    assign s_ready_o      = (level_q != FULL_LVL);
    assign m_valid_o      = (level_q != '0);
    assign almost_full_o  = (level_q >= AF_LVL);
    assign almost_empty_o = (level_q <= AE_LVL);
    assign level_o        = level_q;
    assign m_data_o       = mem_q[rd_ptr_q];

    assign push = s_valid_i && s_ready_o;
    assign pop  = m_valid_o && m_ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            // Pointers are AW bits wide, so DEPTH-1 -> 0 wraps for free.
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is not reset; a flush leaves stale words in place.
    always_ff @(posedge clk) begin
        if (push && !flush_i) mem_q[wr_ptr_q] <= s_data_i;
    end

`ifdef STREAM_FIFO_HWM_EN
    logic [LW-1:0] hwm_q, hwm_d;

    always_comb begin
        hwm_d = hwm_q;
        if (hwm_clr_i || flush_i)  hwm_d = level_d;
        else if (level_d > hwm_q)  hwm_d = level_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hwm_q <= '0;
        else     hwm_q <= hwm_d;
    end

    assign hwm_o = hwm_q;
`else
    logic unused_hwm_clr;
    assign unused_hwm_clr = hwm_clr_i;
    assign hwm_o          = '0;
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Randomized bench for stream_fifo against a queue-based reference model,
// with directed scenarios pinning the model to hand-computed values.
module tb_stream_fifo;
    localparam int W  = 8;
    localparam int D  = 16;
    localparam int LW = 5;

    logic          clk = 1'b0, rst = 1'b1, flush = 1'b0;
    logic          s_valid = 1'b0, m_ready = 1'b0, hwm_clr = 1'b0;
    logic [W-1:0]  s_data = '0;
    logic          s_ready, m_valid, af, ae;
    logic [W-1:0]  m_data;
    logic [LW-1:0] level, hwm;

    stream_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .flush_i(flush),
        .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(s_ready),
        .m_valid_o(m_valid), .m_data_o(m_data), .m_ready_i(m_ready),
        .level_o(level), .almost_full_o(af), .almost_empty_o(ae),
        .hwm_o(hwm), .hwm_clr_i(hwm_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] mq[$];
    int mhwm = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_hwm();
`ifdef STREAM_FIFO_HWM_EN
        return mhwm;
`else
        return 0;
`endif
    endfunction

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("level",    32'(level),   32'(mq.size()));
            chk("s_ready",  32'(s_ready), 32'(mq.size() < D));
            chk("m_valid",  32'(m_valid), 32'(mq.size() > 0));
            chk("afull",    32'(af),      32'(mq.size() >= D - 2));
            chk("aempty",   32'(ae),      32'(mq.size() <= 2));
            chk("hwm",      32'(hwm),     32'(exp_hwm()));
            if (mq.size() > 0) chk("m_data", 32'(m_data), 32'(mq[0]));
        end
    end

    // One clock: model decides push/pop from pre-edge state, then advances.
    task automatic cyc();
        bit do_push, do_pop, fl, clr;
        logic [W-1:0] d;
        do_push = s_valid && (mq.size() < D);
        do_pop  = m_ready && (mq.size() > 0);
        fl = flush; clr = hwm_clr; d = s_data;
        @(posedge clk);
        if (fl) mq.delete();
        else begin
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(d);
        end
        if (fl || clr) mhwm = mq.size();
        else if (mq.size() > mhwm) mhwm = mq.size();
        #1;
    endtask

    task automatic push_n(input int n, input logic [W-1:0] base);
        s_valid = 1'b1; m_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            s_data = base + W'(i);
            cyc();
        end
        s_valid = 1'b0;
    endtask

    task automatic drain();
        s_valid = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < D + 1; i++) cyc();
        m_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level",  32'(level),   0);
        chk("rst_sready", 32'(s_ready), 1);
        chk("rst_mvalid", 32'(m_valid), 0);
        chk("rst_afull",  32'(af),      0);
        chk("rst_aempty", 32'(ae),      1);
        chk("rst_hwm",    32'(hwm),     0);
        rst = 1'b0;

        // Fill to full, then drain in order.
        push_n(16, 8'h00);
        chk("full_level",  32'(level),   16);
        chk("full_sready", 32'(s_ready), 0);
        chk("full_afull",  32'(af),      1);
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", 32'(m_data), 32'(i));
            cyc();
        end
        m_ready = 1'b0;
        chk("drain_empty", 32'(m_valid), 0);

        // Latency of a push into an empty FIFO.
        s_valid = 1'b1; s_data = 8'hA5;
        chk("lat_before", 32'(m_valid), 0);
        cyc();
        s_valid = 1'b0;
        chk("lat_valid", 32'(m_valid), 1);
        chk("lat_data",  32'(m_data),  32'h A5);
        m_ready = 1'b1; cyc(); m_ready = 1'b0;

        // Full with push+pop: only the pop happens, push lands next cycle.
        push_n(16, 8'h20);
        s_valid = 1'b1; m_ready = 1'b1; s_data = 8'h77;
        cyc();
        chk("fullpp_level", 32'(level), 15);
        m_ready = 1'b0;
        cyc();
        chk("fullpp_next", 32'(level), 16);
        drain();

        // Steady streaming at level 5 through pointer wrap.
        push_n(5, 8'h40);
        s_valid = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            s_data = 8'h80 + W'(i);
            cyc();
            chk("stream_level", 32'(level), 5);
        end
        drain();

        // Flush overrides concurrent handshakes.
        flush = 1'b1; cyc(); flush = 1'b0;
        push_n(9, 8'h60);
        chk("pre_flush_level", 32'(level), 9);
`ifdef STREAM_FIFO_HWM_EN
        chk("pre_flush_hwm", 32'(hwm), 9);
`endif
        s_valid = 1'b1; m_ready = 1'b1; flush = 1'b1; s_data = 8'hEE;
        cyc();
        s_valid = 1'b0; m_ready = 1'b0; flush = 1'b0;
        chk("flush_level",  32'(level),   0);
        chk("flush_mvalid", 32'(m_valid), 0);
        chk("flush_sready", 32'(s_ready), 1);
        chk("flush_hwm",    32'(hwm),     0);

        // Asynchronous reset mid-burst.
        push_n(7, 8'h10);
        s_valid = 1'b1; s_data = 8'h99;
        #2 rst = 1'b1;
        #1;
        chk("arst_level",  32'(level),   0);
        chk("arst_mvalid", 32'(m_valid), 0);
        chk("arst_sready", 32'(s_ready), 1);
        chk("arst_aempty", 32'(ae),      1);
        chk("arst_hwm",    32'(hwm),     0);
        mq.delete(); mhwm = 0;
        s_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        s_valid = 1'b1; s_data = 8'h3C;
        cyc();
        s_valid = 1'b0;
        chk("post_rst_valid", 32'(m_valid), 1);
        chk("post_rst_data",  32'(m_data),  32'h3C);
        drain();

        // Random traffic with shifting bias.
        for (int i = 0; i < 3000; i++) begin
            int ph;
            ph = (i / 250) % 3;
            s_valid = ($urandom_range(0, 3) < (ph == 0 ? 3 : (ph == 1 ? 1 : 2)));
            m_ready = ($urandom_range(0, 3) < (ph == 0 ? 1 : (ph == 1 ? 3 : 2)));
            s_data  = W'($urandom);
            flush   = ($urandom_range(0, 63) == 0);
            hwm_clr = ($urandom_range(0, 31) == 0);
            cyc();
        end
        s_valid = 1'b0; m_ready = 1'b0; flush = 1'b0; hwm_clr = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stream_fifo.md
STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 Parameter WIDTH, default 8, payload width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, entry count; a power of two and >=2.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, almost_full asserts when level >= AF_LEVEL.
REQ-004 Parameter AE_LEVEL, default 2, almost_empty asserts when level <= AE_LEVEL.
REQ-005 LW = $clog2(DEPTH)+1 is the width of every level-type output.
REQ-006 clk  in  1  clock; all state updates on its rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 flush  in  1  synchronous discard of all stored entries.
REQ-009 s_valid  in  1  upstream has data.
REQ-010 s_data  in  WIDTH  write payload.
REQ-011 s_ready  out  1  FIFO accepts data (= level < DEPTH).
REQ-012 m_valid  out  1  read data available (= level > 0).
REQ-013 m_data  out  WIDTH  head entry, first-word-fall-through.
REQ-014 m_ready  in  1  downstream consumes head.
REQ-015 level  out  LW  stored entries, 0..DEPTH.
REQ-016 almost_full  out  1  level >= AF_LEVEL.
REQ-017 almost_empty  out  1  level <= AE_LEVEL.
REQ-018 hwm  out  LW  peak level since reset or flush (see Configuration).
REQ-019 hwm_clr  in  1  synchronous clear of hwm (see Configuration).

Function
REQ-020 Push occurs on a rising edge with s_valid && s_ready; s_data is written at wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-021 Pop occurs on a rising edge with m_valid && m_ready; rd_ptr increments modulo DEPTH.
REQ-022 m_data shall equal mem[rd_ptr] combinationally; its value is meaningful only while m_valid=1.
REQ-023 Latency: a push into an empty FIFO at edge N shall raise m_valid after edge N, with no bypass in the same cycle.
REQ-024 Level updates: push-only +1, pop-only -1, push and pop together unchanged, neither unchanged.
REQ-025 Full (level=DEPTH): s_ready=0, no push; a simultaneous pop frees a slot that is visible the next cycle.
REQ-026 Empty (level=0): m_valid=0, no pop; an m_ready assertion is ignored.
REQ-027 Pointer wrap from DEPTH-1 to 0 shall be seamless; data order is strictly FIFO.
REQ-028 flush=1 at an edge shall set wr_ptr, rd_ptr and level to 0, override any same-cycle push or pop, and leave memory contents unchanged.
REQ-029 s_ready, m_valid, almost_full and almost_empty are decoded from the level register only, without combinational paths from s_valid or m_ready.
REQ-030 Arithmetic on level shall be unsigned in LW bits and shall never overflow, because the handshake rules prevent it.

Reset
REQ-031 rst=1 shall immediately clear wr_ptr, rd_ptr, level and hwm, which drives s_ready=1, m_valid=0, level=0, almost_full=0 (for AF_LEVEL>0), almost_empty=1 and hwm=0.
REQ-032 Memory is not reset, and m_data is undefined while m_valid=0.
REQ-033 A reset during traffic discards all entries; the first push after release behaves as a push into an empty FIFO.

Configuration
REQ-034 Macro STREAM_FIFO_HWM_EN enables high-water-mark tracking.
REQ-035 When the macro is defined:
- hwm <= max(hwm, next level) every cycle.
- hwm_clr or flush loads hwm with the current next level.
REQ-036 When the macro is undefined, hwm shall be tied to 0, hwm_clr shall be ignored, and no tracking logic shall be synthesised.

Verification
REQ-037 DEPTH=16: push 0x00..0x0F with m_ready=0 -> level=16, s_ready=0, almost_full=1; pop all -> 0x00..0x0F in order, then m_valid=0.
REQ-038 Push 0xA5 into empty FIFO at edge N -> m_valid=1 and m_data=0xA5 after edge N, not before.
REQ-039 Full FIFO, s_valid=1 and m_ready=1 for one cycle -> only the pop occurs, level=15; next cycle the push is accepted, level=16.
REQ-040 Stream 40 words with s_valid=m_ready=1 continuously at level 5 -> level stays 5, pointers wrap, output order is intact.
REQ-041 level=9, flush with s_valid=m_valid handshakes active -> next cycle level=0, m_valid=0, s_ready=1; with STREAM_FIFO_HWM_EN, hwm goes 9->0.
REQ-042 Assert rst mid-burst at level 7 -> outputs take reset values without waiting for clk; after release, pushing 0x3C yields m_data=0x3C.
